// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD countdown timer with IDLE/RUN/HOLD control and a
// registered one-cycle Done pulse on reaching zero from RUN.
module bcd_countdown #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic                  Dec,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Zero,
    output logic                  Running,
    output logic                  Done
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           done_q, done_d;
    logic [W-1:0]   q_dec;
    logic [W-1:0]   load_sat;
    logic           borrow;
    logic           q_is_zero;
    logic           q_is_one;

    // Ripple borrow across all digits in a single cycle.
    always_comb begin
        q_dec  = q_q;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (q_q[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_sat = LoadVal;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (LoadVal[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    assign q_is_zero = (q_q == '0);
    assign q_is_one  = (q_q == W'(1));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = 1'b0;
        if (Load) begin
            q_d     = load_sat;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start && !q_is_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (Pause) begin
                        state_d = HOLD;
                    end else if (q_is_zero) begin
                        state_d = IDLE;
                    end else if (Dec) begin
                        q_d = q_dec;
                        if (q_is_one) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (Start && !Pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign Zero    = q_is_zero;
    assign Running = (state_q == RUN);
    assign Done    = done_q;

endmodule
